// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters for in-order issue.
// An instruction in ID may issue only when neither of its sources has an
// uncommitted older write and its destination counter has room for another
// in-flight write. WB commits retire pending writes one at a time.
//
// Handshake: issue_fire = issue_valid & issue_ready & exe_allow_in & ~flush.
// issue_ready depends only on registered counter state and the current ID
// operands; it never looks at exe_allow_in, flush or the WB port, so a WB in
// the same cycle does not clear busy (busy drops the cycle after the WB edge).
module reg_scoreboard #(
   parameter int NREG  = 32,
   parameter int CNT_W = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       issue_valid,
   input  logic       issue_rf_w_en,
   input  logic [4:0] issue_w_addr,
   input  logic       src1_used,
   input  logic [4:0] src1_addr,
   input  logic       src2_used,
   input  logic [4:0] src2_addr,
   input  logic       exe_allow_in,
   input  logic       flush,
   input  logic       wb_w_en,
   input  logic [4:0] wb_w_addr,
   output logic       src1_busy,
   output logic       src2_busy,
   output logic       issue_ready,
   output logic       issue_fire,
   output logic [4:0] pending_total,
   output logic       idle
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam int MAX_SUM = NREG * ((1 << CNT_W) - 1);
   localparam int RAW_W   = $clog2(MAX_SUM + 1);
   // Exact running total is kept wide enough to never wrap; the port saturates.
   localparam int TOT_W   = (RAW_W < 6) ? 6 : RAW_W;

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [TOT_W-1:0] total_q;
   logic [TOT_W-1:0] total_d;

   logic [CNT_W-1:0] src1_cnt;
   logic [CNT_W-1:0] src2_cnt;
   logic [CNT_W-1:0] dest_cnt;
   logic [CNT_W-1:0] wb_cnt;
   logic             dest_full;
   logic             inc_en;
   logic             dec_en;
   logic             up;
   logic             dn;

   // Counter lookups for each port; addresses beyond NREG read as zero.
   always_comb begin
      src1_cnt = '0;
      src2_cnt = '0;
      dest_cnt = '0;
      wb_cnt   = '0;
      if (32'(src1_addr) < NREG)    src1_cnt = cnt_q[src1_addr];
      if (32'(src2_addr) < NREG)    src2_cnt = cnt_q[src2_addr];
      if (32'(issue_w_addr) < NREG) dest_cnt = cnt_q[issue_w_addr];
      if (32'(wb_w_addr) < NREG)    wb_cnt   = cnt_q[wb_w_addr];
   end

   // Hazard detection and issue handshake, zero latency from registered state.
   always_comb begin
      src1_busy   = src1_used & (src1_addr != 5'd0) & (src1_cnt != '0);
      src2_busy   = src2_used & (src2_addr != 5'd0) & (src2_cnt != '0);
      dest_full   = issue_rf_w_en & (issue_w_addr != 5'd0) & (dest_cnt == CNT_MAX);
      issue_ready = ~src1_busy & ~src2_busy & ~dest_full;
      issue_fire  = issue_valid & issue_ready & exe_allow_in & ~flush;
      // flush is already folded into issue_fire, so a squashed issue never counts.
      inc_en      = issue_fire & issue_rf_w_en & (issue_w_addr != 5'd0);
      // A commit to an idle register is ignored rather than underflowing.
      dec_en      = wb_w_en & (wb_w_addr != 5'd0) & (wb_cnt != '0);
   end

   // Next counter values: +1 on issue, -1 on commit, unchanged when both hit.
   always_comb begin
      up = 1'b0;
      dn = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         up       = inc_en && (32'(issue_w_addr) == r);
         dn       = dec_en && (32'(wb_w_addr) == r);
         cnt_d[r] = cnt_q[r];
         if (up && !dn)      cnt_d[r] = cnt_q[r] + 1'b1;
         else if (!up && dn) cnt_d[r] = cnt_q[r] - 1'b1;
      end
      total_d = total_q + TOT_W'(inc_en) - TOT_W'(dec_en);
   end

   // State registers; reset wins over any issue or commit in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
         total_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         total_q <= total_d;
      end
   end

   // Registered total presented saturated to the 5-bit port.
   always_comb begin
      pending_total = (total_q > TOT_W'(31)) ? 5'd31 : total_q[4:0];
      idle          = (total_q == '0);
   end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter: NREG, default 32; number of architectural registers tracked.
REQ-002 Parameter: CNT_W, default 2; pending-write counter width per register, so max in-flight writes per register is 2^CNT_W-1.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: issue_valid  input  1  ID presents an instruction for issue to EXE this cycle.
REQ-006 Port: issue_rf_w_en  input  1  issuing instruction writes the register file.
REQ-007 Port: issue_w_addr  input  5  destination register of the issuing instruction.
REQ-008 Port: src1_used / src2_used  input  1 each  the instruction reads src1/src2 from the register file.
REQ-009 Port: src1_addr / src2_addr  input  5 each  source register numbers.
REQ-010 Port: exe_allow_in  input  1  EXE accepts an instruction this cycle.
REQ-011 Port: flush  input  1  branch mispredict cancel; the ID instruction is squashed this cycle.
REQ-012 Port: wb_w_en  input  1  WB commits a register write this cycle.
REQ-013 Port: wb_w_addr  input  5  register committed by WB.
REQ-014 Port: src1_busy / src2_busy  output  1 each  the source has an uncommitted older write.
REQ-015 Port: issue_ready  output  1  the instruction may issue this cycle.
REQ-016 Port: issue_fire  output  1  issue_valid & issue_ready & exe_allow_in & ~flush.
REQ-017 Port: pending_total  output  5  count of in-flight writing instructions, saturating at 31.
REQ-018 Port: idle  output  1  high when no register has pending writes.

Function
REQ-019 Each register r SHALL hold an unsigned CNT_W-bit counter cnt[r].
REQ-020 src1_busy SHALL be src1_used & (src1_addr!=0) & (cnt[src1_addr]!=0); src2_busy SHALL be defined the same way for src2. Both SHALL be combinational from registered state, with zero latency.
REQ-021 dest_full SHALL be issue_rf_w_en & (issue_w_addr!=0) & (cnt[issue_w_addr]==2^CNT_W-1).
REQ-022 issue_ready SHALL be ~src1_busy & ~src2_busy & ~dest_full.
REQ-023 On issue_fire with issue_rf_w_en and issue_w_addr!=0, cnt[issue_w_addr] SHALL increment at the next edge.
REQ-024 On wb_w_en with wb_w_addr!=0 and cnt[wb_w_addr]!=0, cnt[wb_w_addr] SHALL decrement at the next edge.
REQ-025 If the increment and the decrement target the same register in the same cycle, that counter SHALL be unchanged.
REQ-026 A WB write to a register whose counter is 0 SHALL be ignored, with no underflow.
REQ-027 Register 0 SHALL never be counted, and reads of register 0 SHALL never be busy.
REQ-028 When flush is high, no increment SHALL occur; the WB decrement SHALL still apply.
REQ-029 WB bypass within the same cycle SHALL NOT clear busy; busy drops the cycle after the WB edge.
REQ-030 pending_total SHALL track the sum of all counters and be registered, updating on the same edges as the counters.
REQ-031 idle SHALL equal (pending_total==0).

Reset
REQ-032 When reset is high at an edge, all cnt[r] SHALL be 0 and pending_total SHALL be 0; issue_fire and WB inputs SHALL be ignored that cycle.
REQ-033 After reset: idle=1, src1_busy=0, src2_busy=0, issue_ready=1, with a reset asserted mid-operation having the same effect.

Verification
REQ-034 Issue r5 write (fire), then next cycle present src1_addr=5 with src1_used=1 -> src1_busy=1 and issue_ready=0; WB r5 -> busy=0 one cycle after the WB edge.
REQ-035 Issue three writes to r7 with CNT_W=2 -> cnt=3; a fourth write to r7 -> issue_ready=0 and issue_fire=0 until one WB to r7.
REQ-036 Same cycle: issue_fire writing r9 and wb_w_en to r9 with cnt[r9]=1 -> cnt stays 1 and pending_total is unchanged.
REQ-037 Apply flush=1 with issue_valid=1 and exe_allow_in=1 -> issue_fire=0 and no counter change; a simultaneous WB r3 with cnt=1 -> cnt[r3]=0.
REQ-038 Issue a write to r0, and read src1_addr=0 -> no counter change, src1_busy=0; WB to a register with cnt=0 -> no change.
REQ-039 Load 4 pending writes, then assert reset -> idle=1 and pending_total=0 on the next cycle.
